utm_tape: RTL and testbench
===========================

Name: utm_tape

Overview:
Tape unit directly downstream of, and feeding back into, the UTM core (utm_core).
- Holds the tape in a register array and presents the symbol under the head to the core as sym_in/sym_valid.
- Accepts the core's new_sym/direction result, writes the symbol, moves the head and re-issues the next read.
- Provides an idle-time load port so a bench or host can initialise the tape, plus a debug read port.

Parameters:
ADDR_W, 5, head/address width; tape length = 2**ADDR_W cells
SYM_W, 3, symbol width; matches core sym_in/new_sym
BLANK, 3'b000, value every cell holds after reset
INIT_POS, 16, head position after reset
CNT_W, 16, step counter width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin/resume stepping; honoured only in IDLE
stop  in  1  return to IDLE from any state; overrides everything except reset
load_en  in  1  write load_sym to load_addr; honoured only in IDLE
load_addr  in  ADDR_W  load address
load_sym  in  SYM_W  load data
cmd_valid  in  1  core result valid; qualifies new_sym/direction
new_sym  in  SYM_W  symbol to write at head
direction  in  1  1 = move right (head+1), 0 = move left (head-1)
sym_out  out  SYM_W  symbol under head; drives core sym_in
sym_valid  out  1  one-cycle read strobe to core
head  out  ADDR_W  current head position
step_count  out  CNT_W  completed steps, saturating
busy  out  1  high in READ or WAIT
tape_end  out  1  sticky; head tried to leave the tape
dbg_addr  in  ADDR_W  debug read address
dbg_sym  out  SYM_W  combinational tape[dbg_addr]

Behaviour:
- Reset (async, any state):
  - all cells = BLANK; head = INIT_POS; state = IDLE.
  - sym_out = BLANK, sym_valid = 0, step_count = 0, tape_end = 0, busy = 0.
- All outputs except dbg_sym are registered.
- States: IDLE, READ, WAIT, ERR.
- IDLE:
  - load_en writes tape[load_addr] at the clock edge.
  - start -> READ. If start and load_en are both high, the load completes first; READ sees the loaded value.
  - cmd_valid is ignored.
- READ (exactly 1 cycle):
  - sym_valid = 1 and sym_out = tape[head], both valid in this cycle.
  - Next state is WAIT. cmd_valid is ignored in READ.
- WAIT:
  - sym_valid = 0; sym_out holds its value.
  - Without cmd_valid, stays in WAIT indefinitely.
  - On cmd_valid at edge: tape[head] <= new_sym; step_count += 1 (saturates at all-ones).
  - Move right at head = 2**ADDR_W-1, or left at head = 0: write still happens, head unchanged, tape_end <= 1, next state ERR.
  - Otherwise head moves by ±1 and next state is READ. Minimum step loop is 2 cycles.
- ERR:
  - busy = 0; tape_end held high; start and cmd_valid ignored.
  - Only stop or reset exits.
- stop:
  - In any state -> IDLE on the next edge, no tape write (beats a simultaneous cmd_valid); a same-cycle load_en or start is ignored.
  - Clears tape_end; head and step_count retained.
- start in IDLE resumes from the current head; it does not rewind.
- load_en / start outside IDLE: ignored, no side effects.
- dbg_sym reflects writes from the following cycle onward.

Test Plan:
- Reset values: after reset deassert, dbg_sym = 0 at addresses 0, 16, 31; head = 16; sym_valid = 0; step_count = 0; tape_end = 0.
- Load and first read: load tape[16] = 3'b001, then start -> exactly one cycle with sym_valid = 1 and sym_out = 001; busy = 1.
- Single step: in WAIT, cmd_valid with new_sym = 010, direction = 1 -> tape[16] = 010, head = 17, step_count = 1, next cycle sym_valid = 1 with sym_out = tape[17] = 000.
- Left move plus stall: hold cmd_valid low 10 cycles in WAIT -> no change and sym_valid stays 0. Then cmd_valid with new_sym = 011, direction = 0 -> head back at 16, re-read gives sym_out = 010.
- Boundary: load head region, run a left-moving sequence until head = 0, then cmd_valid with direction = 0 -> tape[0] written, head = 0, tape_end = 1, state ERR. Subsequent start ignored; stop clears tape_end.
- Priority and reset: stop asserted together with cmd_valid in WAIT -> no write, no head move, IDLE. Reset asserted mid-WAIT -> all outputs and tape return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/utm_tape.sv
// Tape unit for the UTM core: holds the tape, presents the symbol under the
// head, applies core write/move results and offers idle-time load/debug ports.
module utm_tape #(
    parameter int                 ADDR_W   = 5,
    parameter int                 SYM_W    = 3,
    parameter logic [SYM_W-1:0]   BLANK    = '0,
    parameter int                 INIT_POS = 16,
    parameter int                 CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [SYM_W-1:0]  load_sym,
    input  logic              cmd_valid,
    input  logic [SYM_W-1:0]  new_sym,
    input  logic              direction,
    output logic [SYM_W-1:0]  sym_out,
    output logic              sym_valid,
    output logic [ADDR_W-1:0] head,
    output logic [CNT_W-1:0]  step_count,
    output logic              busy,
    output logic              tape_end,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [SYM_W-1:0]  dbg_sym
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, ERR} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_n;
    logic [SYM_W-1:0]  tape [2**ADDR_W];
    logic [ADDR_W-1:0] head_n, wr_addr;
    logic [SYM_W-1:0]  wr_sym, rd_sym;
    logic              wr_en, step, at_edge;

    assign dbg_sym = tape[dbg_addr];

    always_comb begin
        state_n = state;
        head_n  = head;
        wr_en   = 1'b0;
        wr_addr = head;
        wr_sym  = new_sym;
        step    = 1'b0;
        at_edge = direction ? (head == LAST) : (head == '0);
        case (state)
            IDLE: begin
                if (load_en) begin
                    wr_en   = 1'b1;
                    wr_addr = load_addr;
                    wr_sym  = load_sym;
                end
                if (start) state_n = READ;
            end
            READ: state_n = WAIT;
            WAIT: begin
                if (cmd_valid) begin
                    wr_en = 1'b1;
                    step  = 1'b1;
                    if (at_edge) begin
                        state_n = ERR;
                    end else begin
                        state_n = READ;
                        head_n  = direction ? head + ADDR_W'(1)
                                            : head - ADDR_W'(1);
                    end
                end
            end
            ERR: state_n = ERR;
            default: state_n = IDLE;
        endcase
        if (stop) begin
            state_n = IDLE;
            head_n  = head;
            wr_en   = 1'b0;
            step    = 1'b0;
        end
        // Bypass so a read issued alongside a load sees the new symbol
        rd_sym = (wr_en && wr_addr == head_n) ? wr_sym : tape[head_n];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            head       <= ADDR_W'(INIT_POS);
            sym_out    <= BLANK;
            sym_valid  <= 1'b0;
            step_count <= '0;
            busy       <= 1'b0;
            tape_end   <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) tape[i] <= BLANK;
        end else begin
            state     <= state_n;
            head      <= head_n;
            sym_valid <= (state_n == READ);
            busy      <= (state_n == READ) || (state_n == WAIT);
            if (wr_en) tape[wr_addr] <= wr_sym;
            if (state_n == READ) sym_out <= rd_sym;
            if (step && step_count != '1)
                step_count <= step_count + CNT_W'(1);
            if (stop) tape_end <= 1'b0;
            else if (step && at_edge) tape_end <= 1'b1;
        end
    end

endmodule

// File: tb/tb_utm_tape.sv
// Scoreboard bench for utm_tape: expected read symbols are queued when a read
// is triggered and popped when sym_valid appears.
module tb_utm_tape;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       load_en = 1'b0;
    logic [4:0] load_addr = '0;
    logic [2:0] load_sym = '0;
    logic       cmd_valid = 1'b0;
    logic [2:0] new_sym = '0;
    logic       direction = 1'b0;
    logic [2:0] sym_out;
    logic       sym_valid;
    logic [4:0] head;
    logic [15:0] step_count;
    logic       busy;
    logic       tape_end;
    logic [4:0] dbg_addr = '0;
    logic [2:0] dbg_sym;

    int total = 0;
    int bad = 0;
    int cnt = 0;
    logic [2:0] model [32];
    logic [2:0] exp_q [$];

    utm_tape dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .load_en(load_en), .load_addr(load_addr), .load_sym(load_sym),
        .cmd_valid(cmd_valid), .new_sym(new_sym), .direction(direction),
        .sym_out(sym_out), .sym_valid(sym_valid), .head(head),
        .step_count(step_count), .busy(busy), .tape_end(tape_end),
        .dbg_addr(dbg_addr), .dbg_sym(dbg_sym)
    );

    always #5 clock = ~clock;

    // Releases one-cycle pulses, then waits (bounded) for the read strobe
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clock);
        start = 1'b0; cmd_valid = 1'b0; load_en = 1'b0; stop = 1'b0;
        while (!sym_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [4:0] addrs [3];
        addrs[0] = 5'd0; addrs[1] = 5'd16; addrs[2] = 5'd31;
        for (int i = 0; i < 32; i++) model[i] = 3'b000;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        foreach (addrs[k]) begin
            dbg_addr = addrs[k];
            #1;
            total++;
            if (dbg_sym !== 3'b000) begin
                bad++;
                $display("FAIL reset_cell[%0d]: got %0h want 0", addrs[k], dbg_sym);
            end
        end
        total++;
        if (head !== 5'd16) begin
            bad++; $display("FAIL reset_head: got %0d want 16", head);
        end
        total++;
        if ({sym_valid, busy, tape_end} !== 3'b000 || step_count !== 16'd0 ||
            sym_out !== 3'b000) begin
            bad++;
            $display("FAIL reset_outs: valid=%b busy=%b end=%b cnt=%0d sym=%0h want all 0",
                     sym_valid, busy, tape_end, step_count, sym_out);
        end
    endtask

    task automatic test_load_read();
        int lat;
        logic [2:0] e;
        load_en = 1'b1; load_addr = 5'd16; load_sym = 3'b001; start = 1'b1;
        model[16] = 3'b001;
        exp_q.push_back(model[16]);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0 || sym_valid !== 1'b1) begin
            bad++; $display("FAIL first_read_lat: got %0d want 0", lat);
        end
        total++;
        if (sym_out !== e || busy !== 1'b1) begin
            bad++; $display("FAIL first_read: sym=%0h busy=%b want sym=%0h busy=1", sym_out, busy, e);
        end
        @(negedge clock);
        total++;
        if (sym_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL read_strobe_len: valid=%b busy=%b want 0/1", sym_valid, busy);
        end
    endtask

    task automatic test_single_step();
        int lat;
        logic [2:0] e;
        cmd_valid = 1'b1; new_sym = 3'b010; direction = 1'b1;
        model[16] = 3'b010; cnt++;
        exp_q.push_back(model[17]);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0 || sym_out !== e) begin
            bad++; $display("FAIL step_read: lat=%0d sym=%0h want lat=0 sym=%0h", lat, sym_out, e);
        end
        total++;
        if (head !== 5'd17 || step_count !== 16'(cnt)) begin
            bad++; $display("FAIL step_head: head=%0d cnt=%0d want 17/%0d", head, step_count, cnt);
        end
        dbg_addr = 5'd16;
        #1;
        total++;
        if (dbg_sym !== 3'b010) begin
            bad++; $display("FAIL step_write: got %0h want 2", dbg_sym);
        end
        @(negedge clock);
    endtask

    task automatic test_stall_left();
        int lat;
        int errs = 0;
        logic [2:0] e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (sym_valid !== 1'b0 || head !== 5'd17 || step_count !== 16'(cnt))
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL stall: got %0d bad cycles want 0", errs);
        end
        cmd_valid = 1'b1; new_sym = 3'b011; direction = 1'b0;
        model[17] = 3'b011; cnt++;
        exp_q.push_back(model[16]);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0 || sym_out !== e || head !== 5'd16) begin
            bad++; $display("FAIL left_read: sym=%0h head=%0d want sym=%0h head=16", sym_out, head, e);
        end
        dbg_addr = 5'd17;
        #1;
        total++;
        if (dbg_sym !== 3'b011 || step_count !== 16'(cnt)) begin
            bad++; $display("FAIL left_write: sym=%0h cnt=%0d want 3/%0d", dbg_sym, step_count, cnt);
        end
        @(negedge clock);
    endtask

    task automatic test_boundary();
        int lat;
        int errs = 0;
        logic [4:0] hd;
        logic [2:0] e;
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        total++;
        if (busy !== 1'b0 || head !== 5'd16) begin
            bad++; $display("FAIL stop_to_idle: busy=%b head=%0d want 0/16", busy, head);
        end
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 5'(i); load_sym = 3'((i % 7) + 1);
            model[i] = 3'((i % 7) + 1);
            @(negedge clock);
        end
        load_en = 1'b0;
        start = 1'b1;
        exp_q.push_back(model[16]);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0 || sym_out !== e) begin
            bad++; $display("FAIL resume_read: sym=%0h want %0h", sym_out, e);
        end
        @(negedge clock);
        hd = 5'd16;
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; direction = 1'b0; new_sym = 3'(7 - (i % 7));
            model[hd] = 3'(7 - (i % 7)); cnt++;
            hd = hd - 5'd1;
            exp_q.push_back(model[hd]);
            wait_valid(lat);
            e = exp_q.pop_front();
            if (lat !== 0 || sym_out !== e || head !== hd) errs++;
            @(negedge clock);
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL left_walk: got %0d bad reads want 0", errs);
        end
        cmd_valid = 1'b1; direction = 1'b0; new_sym = 3'b101;
        model[0] = 3'b101; cnt++;
        @(negedge clock);
        cmd_valid = 1'b0;
        dbg_addr = 5'd0;
        #1;
        total++;
        if (tape_end !== 1'b1 || head !== 5'd0 || busy !== 1'b0 || sym_valid !== 1'b0) begin
            bad++; $display("FAIL edge_err: end=%b head=%0d busy=%b valid=%b want 1/0/0/0",
                            tape_end, head, busy, sym_valid);
        end
        total++;
        if (dbg_sym !== 3'b101 || step_count !== 16'(cnt)) begin
            bad++; $display("FAIL edge_write: sym=%0h cnt=%0d want 5/%0d", dbg_sym, step_count, cnt);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || sym_valid !== 1'b0 || tape_end !== 1'b1) begin
            bad++; $display("FAIL err_start: busy=%b valid=%b end=%b want 0/0/1", busy, sym_valid, tape_end);
        end
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        total++;
        if (tape_end !== 1'b0 || head !== 5'd0 || step_count !== 16'(cnt)) begin
            bad++; $display("FAIL err_stop: end=%b head=%0d cnt=%0d want 0/0/%0d", tape_end, head, step_count, cnt);
        end
    endtask

    task automatic test_priority();
        int lat;
        logic [2:0] e;
        start = 1'b1;
        exp_q.push_back(model[0]);
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (lat !== 0 || sym_out !== e) begin
            bad++; $display("FAIL prio_read: sym=%0h want %0h", sym_out, e);
        end
        @(negedge clock);
        stop = 1'b1; cmd_valid = 1'b1; new_sym = 3'b111; direction = 1'b1;
        @(negedge clock);
        stop = 1'b0; cmd_valid = 1'b0;
        dbg_addr = 5'd0;
        #1;
        total++;
        if (busy !== 1'b0 || head !== 5'd0 || dbg_sym !== model[0] || step_count !== 16'(cnt)) begin
            bad++; $display("FAIL stop_beats_cmd: busy=%b head=%0d sym=%0h cnt=%0d want 0/0/%0h/%0d",
                            busy, head, dbg_sym, step_count, model[0], cnt);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b1 || sym_valid !== 1'b0) begin
            bad++; $display("FAIL pre_reset_wait: busy=%b valid=%b want 1/0", busy, sym_valid);
        end
        #2 reset = 1'b0;
        dbg_addr = 5'd0;
        #1;
        total++;
        if (head !== 5'd16 || busy !== 1'b0 || step_count !== 16'd0 || tape_end !== 1'b0 ||
            sym_out !== 3'b000 || dbg_sym !== 3'b000) begin
            bad++; $display("FAIL async_reset: head=%0d busy=%b cnt=%0d end=%b sym=%0h cell0=%0h want 16/0/0/0/0/0",
                            head, busy, step_count, tape_end, sym_out, dbg_sym);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_single_step();
        test_stall_left();
        test_boundary();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
